// File: rtl/qtestpd_onchip_memory_dp_pipe.sv
`default_nettype none
// =============================================================================
// qtestpd_onchip_memory_dp_pipe : true dual-port RAM, two Avalon-MM slaves,
// pipelined reads, cross-port byte-merged forwarding.              Rev 1.0
// =============================================================================
module qtestpd_onchip_memory_dp_pipe #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 7,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_req,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  input  logic                  chipselect2,
  input  logic                  read2,
  input  logic                  write2,
  input  logic [ADDR_W-1:0]     address2,
  input  logic [DATA_W/8-1:0]   byteenable2,
  input  logic [DATA_W-1:0]     writedata2,
  output logic [DATA_W-1:0]     readdata2,
  output logic                  readdatavalid2,
  output logic                  waitrequest2
);

  localparam int c_BE_W  = DATA_W / 8;
  localparam int c_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [c_DEPTH];
  logic              prio_q;  // 0: s1 wins the next collision, 1: s2 wins

  logic [ADDR_W-1:0] w_addr  [2];
  logic [c_BE_W-1:0] w_be    [2];
  logic [DATA_W-1:0] w_wdata [2];
  logic [DATA_W-1:0] w_rdata [2];
  logic [1:0]        w_rvalid;
  logic [1:0]        w_req, w_wreq, w_rd_only, w_lose, w_stall, w_acc, w_wacc, w_racc;
  logic              w_coll;

  assign w_addr[0]  = address;
  assign w_addr[1]  = address2;
  assign w_be[0]    = byteenable;
  assign w_be[1]    = byteenable2;
  assign w_wdata[0] = writedata;
  assign w_wdata[1] = writedata2;

  assign w_req     = {chipselect2 & (read2 | write2), chipselect & (read | write)};
  assign w_wreq    = {chipselect2 & write2, chipselect & write};
  assign w_rd_only = {read2 & ~write2, read & ~write};

  // Collisions are only arbitrated while the ports are open; under reset_req
  // nobody is granted, so the round-robin order is left untouched.
  assign w_coll  = w_wreq[0] & w_wreq[1] & (w_addr[0] == w_addr[1]) & ~reset_req;
  assign w_lose  = {w_coll & ~prio_q, w_coll & prio_q};
  assign w_stall = {2{reset | reset_req}} | w_lose;
  assign w_acc   = w_req & ~w_stall;
  assign w_wacc  = w_acc & w_wreq;
  assign w_racc  = w_acc & w_rd_only;

  assign waitrequest    = w_stall[0];
  assign waitrequest2   = w_stall[1];
  assign readdata       = w_rdata[0];
  assign readdata2      = w_rdata[1];
  assign readdatavalid  = w_rvalid[0];
  assign readdatavalid2 = w_rvalid[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else if (w_coll) begin
      prio_q <= ~prio_q;
    end
  end

  // Accepted writes never share an address, so the two ports cannot race.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < c_BE_W; b++) begin
        if (w_wacc[p] && w_be[p][b]) begin
          mem_q[w_addr[p]][8*b +: 8] <= w_wdata[p][8*b +: 8];
        end
      end
    end
  end

  for (genvar gp = 0; gp < 2; gp++) begin : g_port
    localparam int c_OTH = 1 - gp;

    logic [DATA_W-1:0]       rword_d;
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]       dat_q [READ_LATENCY];

    always_comb begin
      rword_d = mem_q[w_addr[gp]];
      for (int b = 0; b < c_BE_W; b++) begin
        if (w_wacc[c_OTH] && (w_addr[c_OTH] == w_addr[gp]) && w_be[c_OTH][b]) begin
          rword_d[8*b +: 8] = w_wdata[c_OTH][8*b +: 8];
        end
      end
    end

    // Each stage only loads on valid, so the last stage holds readdata between pulses.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
          dat_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= w_racc[gp];
        if (w_racc[gp]) begin
          dat_q[0] <= rword_d;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) begin
            dat_q[i] <= dat_q[i-1];
          end
        end
      end
    end

    assign w_rdata[gp]  = dat_q[READ_LATENCY-1];
    assign w_rvalid[gp] = vld_q[READ_LATENCY-1];
  end

endmodule
`default_nettype wire

// File: tb/tb_qtestpd_onchip_memory_dp_pipe.sv
`default_nettype none
// tb_qtestpd_onchip_memory_dp_pipe: identical stimulus into a READ_LATENCY=1 (u_a)
// and a READ_LATENCY=2 (u_b) instance, checked by a queue scoreboard.
module tb_qtestpd_onchip_memory_dp_pipe;
  localparam int AW = 7;

  typedef struct {
    bit          cs, rd, wr;
    logic [AW-1:0] a;
    logic [7:0]  be;
    logic [63:0] d;
  } op_t;

  typedef struct {
    int          c;
    logic [63:0] d;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1, reset_req = 1'b0;
  logic cs1 = 1'b0, rd1 = 1'b0, wr1 = 1'b0, cs2 = 1'b0, rd2 = 1'b0, wr2 = 1'b0;
  logic [AW-1:0] ad1 = '0, ad2 = '0;
  logic [7:0]    be1 = '0, be2 = '0;
  logic [63:0]   wd1 = '0, wd2 = '0;
  logic [63:0]   rdA1, rdA2, rdB1, rdB2;
  logic          rvA1, rvA2, rvB1, rvB2, wtA1, wtA2, wtB1, wtB2;

  int checks = 0, errors = 0, cyc = 0;
  logic [63:0] mm [128];
  bit          prio_m = 1'b0;
  exp_t        qA1[$], qA2[$], qB1[$], qB2[$];
  logic [63:0] lastA1 = '0, lastA2 = '0, lastB1 = '0, lastB2 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qtestpd_onchip_memory_dp_pipe #(.DATA_W(64), .ADDR_W(AW), .READ_LATENCY(1)) u_a (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .chipselect(cs1), .read(rd1), .write(wr1), .address(ad1), .byteenable(be1),
    .writedata(wd1), .readdata(rdA1), .readdatavalid(rvA1), .waitrequest(wtA1),
    .chipselect2(cs2), .read2(rd2), .write2(wr2), .address2(ad2), .byteenable2(be2),
    .writedata2(wd2), .readdata2(rdA2), .readdatavalid2(rvA2), .waitrequest2(wtA2));

  qtestpd_onchip_memory_dp_pipe #(.DATA_W(64), .ADDR_W(AW), .READ_LATENCY(2)) u_b (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .chipselect(cs1), .read(rd1), .write(wr1), .address(ad1), .byteenable(be1),
    .writedata(wd1), .readdata(rdB1), .readdatavalid(rvB1), .waitrequest(wtB1),
    .chipselect2(cs2), .read2(rd2), .write2(wr2), .address2(ad2), .byteenable2(be2),
    .writedata2(wd2), .readdata2(rdB2), .readdatavalid2(rvB2), .waitrequest2(wtB2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_rd(input string nm, input exp_t e, input logic [63:0] act);
    checks++;
    if (act !== e.d || cyc != e.c) begin
      errors++;
      $display("FAIL %s actual=%h@cyc%0d required=%h@cyc%0d", nm, act, cyc, e.d, e.c);
    end
  endtask

  task automatic spurious(input string nm);
    checks++;
    errors++;
    $display("FAIL %s readdatavalid with nothing outstanding at cyc%0d", nm, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a readdatavalid is presented.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (rvA1) begin
        if (qA1.size() == 0) spurious("A_s1"); else begin e = qA1.pop_front(); chk_rd("A_s1", e, rdA1); end
        lastA1 = rdA1;
      end
      if (rvA2) begin
        if (qA2.size() == 0) spurious("A_s2"); else begin e = qA2.pop_front(); chk_rd("A_s2", e, rdA2); end
        lastA2 = rdA2;
      end
      if (rvB1) begin
        if (qB1.size() == 0) spurious("B_s1"); else begin e = qB1.pop_front(); chk_rd("B_s1", e, rdB1); end
        lastB1 = rdB1;
      end
      if (rvB2) begin
        if (qB2.size() == 0) spurious("B_s2"); else begin e = qB2.pop_front(); chk_rd("B_s2", e, rdB2); end
        lastB2 = rdB2;
      end
    end
  end

  function automatic op_t mk(bit rd, bit wr, int a, logic [7:0] be, logic [63:0] d);
    op_t o;
    o.cs = rd | wr; o.rd = rd; o.wr = wr; o.a = AW'(a); o.be = be; o.d = d;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.cs = ($urandom_range(0, 3) != 0);
    o.rd = $urandom_range(0, 1) == 1;
    o.wr = $urandom_range(0, 1) == 1;
    o.a  = AW'($urandom_range(0, 7));
    o.be = 8'($urandom);
    o.d  = {$urandom, $urandom};
    return o;
  endfunction

  task automatic wr_model(input op_t o);
    for (int b = 0; b < 8; b++) begin
      if (o.be[b]) mm[o.a][8*b +: 8] = o.d[8*b +: 8];
    end
  endtask

  // One bus cycle: drive at posedge+1, check waitrequest at posedge+4, update model.
  task automatic step(input op_t o1, input op_t o2, input bit rq, output bit k1, output bit k2);
    bit q1, q2, coll, e1, e2;
    int c0;
    exp_t e;
    cs1 = o1.cs; rd1 = o1.rd; wr1 = o1.wr; ad1 = o1.a; be1 = o1.be; wd1 = o1.d;
    cs2 = o2.cs; rd2 = o2.rd; wr2 = o2.wr; ad2 = o2.a; be2 = o2.be; wd2 = o2.d;
    reset_req = rq;
    q1   = o1.cs & (o1.rd | o1.wr);
    q2   = o2.cs & (o2.rd | o2.wr);
    coll = o1.cs & o1.wr & o2.cs & o2.wr & (o1.a == o2.a) & !rq;
    e1   = rq | (coll & prio_m);
    e2   = rq | (coll & !prio_m);
    #3;
    chk("A_wait_s1", 64'(wtA1), 64'(e1));
    chk("A_wait_s2", 64'(wtA2), 64'(e2));
    chk("B_wait_s1", 64'(wtB1), 64'(e1));
    chk("B_wait_s2", 64'(wtB2), 64'(e2));
    k1 = q1 & !e1;
    k2 = q2 & !e2;
    if (k1 && o1.wr) wr_model(o1);
    if (k2 && o2.wr) wr_model(o2);
    c0 = cyc;
    if (k1 && o1.rd && !o1.wr) begin
      e.d = mm[o1.a];
      e.c = c0 + 1; qA1.push_back(e);
      e.c = c0 + 2; qB1.push_back(e);
    end
    if (k2 && o2.rd && !o2.wr) begin
      e.d = mm[o2.a];
      e.c = c0 + 1; qA2.push_back(e);
      e.c = c0 + 2; qB2.push_back(e);
    end
    if (coll) prio_m = !prio_m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    op_t idle_op, o1, o2;
    bit  k1, k2, rq, h1, h2;
    idle_op = mk(0, 0, 0, 8'h00, 64'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdA1", rdA1, 64'h0); chk("rst_rdA2", rdA2, 64'h0);
    chk("rst_rdB1", rdB1, 64'h0); chk("rst_rdB2", rdB2, 64'h0);
    chk("rst_rv", {rvA1, rvA2, rvB1, rvB2}, 64'h0);
    chk("rst_wait", {wtA1, wtA2, wtB1, wtB2}, 64'hF);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full write then cross-port read
    step(mk(0, 1, 5, 8'hFF, 64'h0123456789ABCDEF), idle_op, 0, k1, k2);
    step(idle_op, mk(1, 0, 5, 8'h00, 64'h0), 0, k1, k2);
    repeat (3) step(idle_op, idle_op, 0, k1, k2);
    chk("t1_A_s2", lastA2, 64'h0123456789ABCDEF);
    chk("t1_B_s2", lastB2, 64'h0123456789ABCDEF);

    // Partial write forwarded to a same-cycle read on the other port
    step(mk(0, 1, 5, 8'h0F, 64'hFFFFFFFFFFFFFFFF), mk(1, 0, 5, 8'h00, 64'h0), 0, k1, k2);
    repeat (3) step(idle_op, idle_op, 0, k1, k2);
    chk("t2_A_s2", lastA2, 64'h01234567FFFFFFFF);
    chk("t2_B_s2", lastB2, 64'h01234567FFFFFFFF);

    // Round-robin collisions on address 9
    step(mk(0, 1, 9, 8'hFF, 64'h11), mk(0, 1, 9, 8'hFF, 64'h22), 0, k1, k2);
    step(idle_op, mk(0, 1, 9, 8'hFF, 64'h22), 0, k1, k2);
    step(mk(1, 0, 9, 8'h00, 64'h0), idle_op, 0, k1, k2);
    repeat (3) step(idle_op, idle_op, 0, k1, k2);
    chk("t3_first", lastB1, 64'h22);
    step(mk(0, 1, 9, 8'hFF, 64'h33), mk(0, 1, 9, 8'hFF, 64'h44), 0, k1, k2);
    step(mk(0, 1, 9, 8'hFF, 64'h33), idle_op, 0, k1, k2);
    step(idle_op, mk(1, 0, 9, 8'h00, 64'h0), 0, k1, k2);
    repeat (3) step(idle_op, idle_op, 0, k1, k2);
    chk("t3_second", lastB2, 64'h33);

    // Back-to-back streaming reads of 0..7
    for (int i = 0; i < 4; i++)
      step(mk(0, 1, i, 8'hFF, 64'h100 + 64'(i)), mk(0, 1, i + 4, 8'hFF, 64'h104 + 64'(i)), 0, k1, k2);
    for (int i = 0; i < 8; i++) step(mk(1, 0, i, 8'h00, 64'h0), idle_op, 0, k1, k2);
    repeat (4) step(idle_op, idle_op, 0, k1, k2);
    chk("t4_last", lastB1, 64'h107);

    // reset_req drains in-flight reads and blocks new ones
    step(mk(1, 0, 0, 8'h00, 64'h0), mk(1, 0, 1, 8'h00, 64'h0), 0, k1, k2);
    repeat (4) step(mk(1, 0, 2, 8'h00, 64'h0), mk(1, 0, 3, 8'h00, 64'h0), 1, k1, k2);
    chk("t5_drained", 64'(qB1.size() + qB2.size()), 64'h0);
    step(mk(1, 0, 2, 8'h00, 64'h0), mk(1, 0, 3, 8'h00, 64'h0), 0, k1, k2);
    repeat (4) step(idle_op, idle_op, 0, k1, k2);
    chk("t5_after_B_s2", lastB2, 64'h103);

    // Randomised traffic, stalled requests held by the master
    h1 = 1'b0; h2 = 1'b0; o1 = idle_op; o2 = idle_op;
    for (int n = 0; n < 400; n++) begin
      if (!h1) o1 = rnd_op();
      if (!h2) o2 = rnd_op();
      rq = ($urandom_range(0, 15) == 0);
      step(o1, o2, rq, k1, k2);
      h1 = o1.cs & (o1.rd | o1.wr) & !k1;
      h2 = o2.cs & (o2.rd | o2.wr) & !k2;
    end
    repeat (4) step(idle_op, idle_op, 0, k1, k2);

    // Reset the cycle after a read is accepted
    step(mk(1, 0, 3, 8'h00, 64'h0), idle_op, 0, k1, k2);
    reset = 1'b1;
    qA1.delete(); qA2.delete(); qB1.delete(); qB2.delete();
    prio_m = 1'b0;
    #3;
    chk("t6_wait", {wtA1, wtA2, wtB1, wtB2}, 64'hF);
    chk("t6_rv", {rvA1, rvA2, rvB1, rvB2}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_rdB1", rdB1, 64'h0);
    chk("t6_rv_hold", {rvA1, rvB1}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(idle_op, idle_op, 0, k1, k2);
    chk("t6_rdB1_after", rdB1, 64'h0);
    step(mk(0, 1, 10, 8'hFF, 64'h55), mk(0, 1, 10, 8'hFF, 64'h66), 0, k1, k2);
    step(idle_op, mk(0, 1, 10, 8'hFF, 64'h66), 0, k1, k2);
    step(mk(1, 0, 10, 8'h00, 64'h0), idle_op, 0, k1, k2);
    repeat (3) step(idle_op, idle_op, 0, k1, k2);
    chk("t6_prio", lastB1, 64'h66);

    chk("end_qA", 64'(qA1.size() + qA2.size()), 64'h0);
    chk("end_qB", 64'(qB1.size() + qB2.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qtestpd_onchip_memory_dp_pipe.md
# qtestpd_onchip_memory_dp_pipe

Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2) on one clock. It is the pipelined successor of the fixed 128x64 dual-port memory, and sits as a shared buffer between two masters in the qtestpd system. It adds configurable width and depth, a configurable registered read latency with `readdatavalid`, and byte-merged mixed-port read-during-write forwarding. Same-address write collisions are resolved by a round-robin stall on `waitrequest`.

## Interface
Parameters:
- `DATA_W`, default 64: word width; must be a multiple of 8.
- `ADDR_W`, default 7: word address width; depth is 2**`ADDR_W`.
- `READ_LATENCY`, default 1: cycles from read acceptance to `readdatavalid`; legal values are 1 or 2.

Ports (x = 1 for port s1, x = 2 for port s2):
- `clk`  in  1  single clock for both ports.
- `reset`  in  1  asynchronous, active-high reset.
- `reset_req`  in  1  quiesce request; blocks new accepts on both ports.
- `chipselect`/`chipselect2`  in  1  port select.
- `read`/`read2`  in  1  read request.
- `write`/`write2`  in  1  write request.
- `address`/`address2`  in  `ADDR_W`  word address.
- `byteenable`/`byteenable2`  in  `DATA_W/8`  write byte lanes.
- `writedata`/`writedata2`  in  `DATA_W`  write data.
- `readdata`/`readdata2`  out  `DATA_W`  registered read data.
- `readdatavalid`/`readdatavalid2`  out  1  one-cycle pulse marking valid read data.
- `waitrequest`/`waitrequest2`  out  1  stall; the master holds its request while this is high.

## Operation
- Request on port x: `chipselect`x & (`read`x | `write`x).
- Accept on port x: request & ~`waitrequest`x.
- If `read`x and `write`x are both high, the request is a write only. No `readdatavalid` is produced.
- `waitrequest`x is combinational from inputs and the priority flag only. It is high when any of the following holds:
  - `reset` is high;
  - `reset_req` is high;
  - port x loses a collision.
- Collision: both ports request a write to the same address in the same cycle.
  - Winner: the port not granted at the last collision. After reset, s1 wins first.
  - The priority flag toggles on every collision.
  - The loser stalls exactly 1 cycle, then completes unless a new collision occurs.
- Write: at the accepting edge, only bytes with the matching `byteenable` bit set are updated. `byteenable` = 0 is accepted and changes nothing.
- Read: returns the word at `address`, captured at the accepting edge. The word passes through a `READ_LATENCY`-deep valid/data pipeline per port.
- Mixed-port read-during-write: port x reads address A in the same cycle the other port's write to A is accepted.
  - Result: a byte merge. Enabled bytes come from the new `writedata`; the other bytes keep their old contents.
  - A write that is stalled by a collision is not accepted, so a same-cycle read of that address returns old data.
- A read and a write on different addresses are fully independent.
- Each port sustains 1 accepted request per cycle. Reads and writes may be interleaved without bubbles.
- `reset_req` high: in-flight reads still drain and produce `readdatavalid`; no new requests are accepted.
- Memory array contents are not reset. Contents are undefined until written.
- `reset` asserted mid-operation: pipelines clear immediately, and in-flight reads are dropped (no `readdatavalid`).

## Timing
- Reset values: `readdata` and `readdata2` = 0; `readdatavalid` and `readdatavalid2` = 0; priority flag = s1. `waitrequest` and `waitrequest2` are high while `reset` is high.
- Read accepted at edge k → `readdatavalid` high for exactly one cycle after edge k+`READ_LATENCY`-1, with `readdata` valid in the same cycle.
  - `READ_LATENCY`=1: data is available in the cycle immediately after the accepting edge.
- `readdata` holds its last value when `readdatavalid` is low.
- Write accepted at edge k → a read accepted at edge k+1 on either port returns the new data.
- `waitrequest` has no registered stage. A stall is resolved within the same cycle the request is presented.

## Test plan
- Reset with `DATA_W`=64, `ADDR_W`=7, `READ_LATENCY`=1.
  - Stimulus: s1 writes 0x0123456789ABCDEF to address 5 with `byteenable`=0xFF, then s2 reads address 5.
  - Required: `readdatavalid2` pulses 1 cycle after the read is accepted, with `readdata2`=0x0123456789ABCDEF.
- Byte-enable and mixed-port forwarding.
  - Stimulus: address 5 holds 0x0123456789ABCDEF. In the same cycle, s1 writes 0xFFFFFFFFFFFFFFFF with `byteenable`=0x0F and s2 reads address 5.
  - Required: `readdata2`=0x01234567FFFFFFFF.
- Collision round-robin.
  - Stimulus: both ports write address 9 simultaneously, s1=0x11 and s2=0x22.
  - Required: `waitrequest2` is high for 1 cycle; the final contents of address 9 are 0x22.
  - Stimulus: repeat with s1=0x33 and s2=0x44.
  - Required: `waitrequest` (s1) is high for 1 cycle; the final contents are 0x33.
- Pipelined streaming at `READ_LATENCY`=2.
  - Stimulus: s1 issues reads to addresses 0..7 back-to-back, previously written with values 0x100+addr.
  - Required: 8 consecutive `readdatavalid` cycles starting 2 cycles after the first accept, data in order, no `waitrequest`.
- `reset_req` drain.
  - Stimulus: 2 reads are in flight at `READ_LATENCY`=2, then `reset_req` is raised.
  - Required: both reads complete; `waitrequest` and `waitrequest2` stay high until `reset_req` drops; a new read issued meanwhile is not accepted.
- Reset mid-read.
  - Stimulus: assert `reset` the cycle after a read is accepted at `READ_LATENCY`=2.
  - Required: `readdatavalid` never pulses and `readdata`=0. After reset, the priority flag again favours s1.
